// File: rtl/bufmem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// bufmem_arbiter_pkg : shared arbiter state encoding and default map constants
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bufmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOST = 2'd1,
      ST_CPU  = 2'd2
   } arb_state_t;

   localparam logic [15:0] DEFAULT_CPU_BASE       = 16'h0200;
   localparam int          DEFAULT_HOST_BURST_MAX = 4;

endpackage

`default_nettype wire

// File: rtl/bufmem_arbiter.sv
//------------------------------------------------------------------------------
// bufmem_arbiter : two-port (host / CPU) arbiter in front of a single-port RAM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bufmem_arbiter
   import bufmem_arbiter_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 10,
   parameter int          DATA_WIDTH     = 8,
   parameter logic [15:0] CPU_BASE       = DEFAULT_CPU_BASE,
   parameter int          HOST_BURST_MAX = DEFAULT_HOST_BURST_MAX
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_ack,
   output logic                  host_rvalid,
   output logic [DATA_WIDTH-1:0] host_rdata,
   input  logic [15:0]           cpu_addr,
   input  logic                  cpu_we,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_hold,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam int              CNT_W       = (HOST_BURST_MAX < 1) ? 1 : $clog2(HOST_BURST_MAX + 1);
   localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(HOST_BURST_MAX);

   arb_state_t             state;
   arb_state_t             state_nxt;
   logic [CNT_W-1:0]       burst_cnt;
   logic [CNT_W-1:0]       burst_nxt;
   logic                   rd_pend;
   logic                   rd_pend_nxt;
   logic                   host_grant;
   logic                   cpu_grant;
   logic                   cpu_sel;
   logic [16:0]            cpu_off;
   logic [ADDR_WIDTH-1:0]  cpu_buf_addr;

   // 17-bit difference: addresses below the base wrap into bit 16 and fall out of the window
   assign cpu_off      = {1'b0, cpu_addr} - {1'b0, CPU_BASE};
   assign cpu_sel      = (cpu_off[16:ADDR_WIDTH] == '0);
   assign cpu_buf_addr = cpu_off[ADDR_WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         burst_cnt <= '0;
         rd_pend   <= 1'b0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_nxt;
         rd_pend   <= rd_pend_nxt;
      end
   end

   always_comb begin
      host_grant  = 1'b0;
      cpu_grant   = 1'b0;
      state_nxt   = ST_IDLE;
      burst_nxt   = burst_cnt;
      rd_pend_nxt = 1'b0;
      ram_cs      = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;

      if (!reset) begin
         if (host_req && !(cpu_sel && burst_cnt == BURST_LIMIT)) begin
            host_grant = 1'b1;
         end else if (cpu_sel) begin
            cpu_grant = 1'b1;
         end
      end

      if (host_grant) begin
         state_nxt   = ST_HOST;
         rd_pend_nxt = ~host_we;
         ram_cs      = 1'b1;
         ram_we      = host_we;
         ram_addr    = host_addr;
         ram_wdata   = host_wdata;
      end else if (cpu_grant) begin
         state_nxt   = ST_CPU;
         rd_pend_nxt = ~cpu_we;
         ram_cs      = 1'b1;
         ram_we      = cpu_we;
         ram_addr    = cpu_buf_addr;
         ram_wdata   = cpu_wdata;
      end

      // The host streak only counts while the CPU is actually waiting
      if (!cpu_sel || cpu_grant) begin
         burst_nxt = '0;
      end else if (host_grant && burst_cnt != BURST_LIMIT) begin
         burst_nxt = burst_cnt + 1'b1;
      end
   end

   assign host_ack    = host_grant;
   assign cpu_hold    = cpu_sel & ~cpu_grant & ~reset;

   // Last cycle's owner doubles as the read-return tag
   assign host_rvalid = rd_pend && (state == ST_HOST);
   assign cpu_rvalid  = rd_pend && (state == ST_CPU);
   assign host_rdata  = reset ? '0 : ram_rdata;
   assign cpu_rdata   = reset ? '0 : ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_bufmem_arbiter.sv
//------------------------------------------------------------------------------
// tb_bufmem_arbiter : randomized bench with behavioural arbiter and memory model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bufmem_arbiter;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int BURST = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          host_req, host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_ack, host_rvalid;
   logic [DW-1:0] host_rdata;
   logic [15:0]   cpu_addr;
   logic          cpu_we;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_hold, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          ram_cs, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;

   logic [DW-1:0] ram_mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   int checks   = 0;
   int failures = 0;
   int streak   = 0;
   bit last_hg, last_cg, last_sel;
   int n_hack, n_cgrant, n_hold;

   always #5 clk = ~clk;

   bufmem_arbiter #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .CPU_BASE       (16'h0200),
      .HOST_BURST_MAX (BURST)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_ack    (host_ack),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .cpu_addr    (cpu_addr),
      .cpu_we      (cpu_we),
      .cpu_wdata   (cpu_wdata),
      .cpu_hold    (cpu_hold),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_rdata   (cpu_rdata),
      .ram_cs      (ram_cs),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   // Synchronous single-port RAM standing in for the external wrapper
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata        <= ram_mem[ram_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_host_ack"},    32'(host_ack),    0);
      check_eq({tag, "_cpu_hold"},    32'(cpu_hold),    0);
      check_eq({tag, "_ram_cs"},      32'(ram_cs),      0);
      check_eq({tag, "_ram_we"},      32'(ram_we),      0);
      check_eq({tag, "_ram_addr"},    32'(ram_addr),    0);
      check_eq({tag, "_ram_wdata"},   32'(ram_wdata),   0);
      check_eq({tag, "_host_rvalid"}, 32'(host_rvalid), 0);
      check_eq({tag, "_cpu_rvalid"},  32'(cpu_rvalid),  0);
      check_eq({tag, "_host_rdata"},  32'(host_rdata),  0);
      check_eq({tag, "_cpu_rdata"},   32'(cpu_rdata),   0);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 4))
         0:       return '1;
         1:       return r[AW-1:0];
         default: return AW'($urandom_range(0, 15));
      endcase
   endfunction

   function automatic logic [15:0] rand_cpu_addr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0:       return 16'h01FF;
         1:       return 16'h0600;
         2:       return 16'h05FF;
         3:       return r[15:0];
         default: return 16'h0200 + {6'd0, rand_addr()};
      endcase
   endfunction

   // One clock of the reference model: grant decision, memory effect, read return
   task automatic do_cycle();
      int            off;
      bit            sel, hg, cg, exp_hrv, exp_crv;
      logic [AW-1:0] a;
      logic [DW-1:0] exp_data;
      @(negedge clk);
      off = int'(cpu_addr) - 32'h200;
      sel = (off >= 0) && (off < (1 << AW));
      hg  = host_req && !(sel && streak >= BURST);
      cg  = sel && !hg;
      check_eq("host_ack", 32'(host_ack), 32'(hg));
      check_eq("cpu_hold", 32'(cpu_hold), 32'(sel && !cg));
      check_eq("ram_cs",   32'(ram_cs),   32'(hg || cg));
      n_hack   += int'(host_ack);
      n_hold   += int'(cpu_hold);
      n_cgrant += int'(ram_cs && !host_ack);
      exp_hrv  = 1'b0;
      exp_crv  = 1'b0;
      exp_data = '0;
      if (hg || cg) begin
         a = hg ? host_addr : off[AW-1:0];
         check_eq("ram_we",   32'(ram_we),   32'(hg ? host_we : cpu_we));
         check_eq("ram_addr", 32'(ram_addr), 32'(a));
         exp_data = ref_mem[a];
         if (hg ? host_we : cpu_we) begin
            check_eq("ram_wdata", 32'(ram_wdata), 32'(hg ? host_wdata : cpu_wdata));
            ref_mem[a] = hg ? host_wdata : cpu_wdata;
         end else begin
            exp_hrv = hg;
            exp_crv = cg;
         end
      end
      streak   = (hg && sel) ? streak + 1 : 0;
      last_hg  = hg;
      last_cg  = cg;
      last_sel = sel;
      @(posedge clk);
      #1;
      check_eq("host_rvalid", 32'(host_rvalid), 32'(exp_hrv));
      check_eq("cpu_rvalid",  32'(cpu_rvalid),  32'(exp_crv));
      if (exp_hrv) check_eq("host_rdata", 32'(host_rdata), 32'(exp_data));
      if (exp_crv) check_eq("cpu_rdata",  32'(cpu_rdata),  32'(exp_data));
   endtask

   // Requesters keep their access stable until it is served
   task automatic drive_next(input int host_pct, input bit cpu_always);
      if (!host_req || last_hg) begin
         host_req   = ($urandom_range(0, 99) < host_pct);
         host_we    = 1'($urandom_range(0, 1));
         host_addr  = rand_addr();
         host_wdata = DW'($urandom_range(0, 255));
      end
      if (!last_sel || last_cg) begin
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_wdata = DW'($urandom_range(0, 255));
         cpu_addr  = cpu_always ? 16'h0200 + {6'd0, rand_addr()} : rand_cpu_addr();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ram_mem[i] = DW'($urandom_range(0, 255));
         ref_mem[i] = ram_mem[i];
      end
      ram_mem[3] = 8'hA5;
      ref_mem[3] = 8'hA5;

      // Requests active during reset must not leak through
      reset = 1'b1;
      host_req = 1'b1; host_we = 1'b1; host_addr = 10'd5; host_wdata = 8'h33;
      cpu_addr = 16'h0203; cpu_we = 1'b1; cpu_wdata = 8'h11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0; host_req = 1'b0; cpu_addr = 16'h0000;
      streak = 0;

      cpu_addr = 16'h0203; cpu_we = 1'b0;
      do_cycle();
      check_eq("cpu_read_preload", 32'(cpu_rdata), 32'h A5);

      cpu_addr = 16'h0600; cpu_we = 1'b1; cpu_wdata = 8'h77;
      do_cycle();

      cpu_addr = 16'h0000;
      host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FF; host_wdata = 8'h5A;
      do_cycle();
      host_req = 1'b0;
      cpu_addr = 16'h05FF; cpu_we = 1'b0;
      do_cycle();
      check_eq("host_wr_cpu_rd", 32'(cpu_rdata), 32'h5A);

      // Read then write to the same address back to back
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'd9; cpu_addr = 16'h0000;
      do_cycle();
      host_we = 1'b1; host_wdata = 8'hC3;
      do_cycle();
      host_we = 1'b0;
      do_cycle();
      check_eq("rd_after_wr", 32'(host_rdata), 32'hC3);

      // Continuous contention: four host grants per CPU grant
      host_req = 1'b0; cpu_addr = 16'h0000;
      do_cycle();
      n_hack = 0; n_cgrant = 0; n_hold = 0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'd1;
      cpu_addr = 16'h0210; cpu_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         do_cycle();
         if (last_hg) host_addr = rand_addr();
         if (last_cg) begin
            cpu_addr = 16'h0200 + {6'd0, rand_addr()};
            cpu_we   = 1'($urandom_range(0, 1));
         end
      end
      check_eq("burst_host_acks",  32'(n_hack),   8);
      check_eq("burst_cpu_grants", 32'(n_cgrant), 2);
      check_eq("burst_hold_cycles", 32'(n_hold),  8);

      // Reset in the cycle following a host read grant
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'd7; cpu_addr = 16'h0000;
      @(negedge clk);
      check_eq("rst_pre_ack", 32'(host_ack), 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_eq("rst_drop_rvalid", 32'(host_rvalid), 0);
      @(negedge clk);
      check_all_zero("mid_reset");
      @(posedge clk);
      #1;
      reset = 1'b0; host_req = 1'b0;
      streak = 0;
      @(posedge clk);
      #1;
      check_eq("post_rst_host_rvalid", 32'(host_rvalid), 0);
      check_eq("post_rst_cpu_rvalid",  32'(cpu_rvalid),  0);

      last_hg = 1'b1; last_cg = 1'b1; last_sel = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         drive_next(60, 1'b0);
         do_cycle();
      end
      for (int i = 0; i < 300; i++) begin
         drive_next(90, 1'b1);
         do_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
